vermibus_arbiter: RTL

VERMIBUS_ARBITER -- requirements
Module: vermibus_arbiter

---
 rtl/vermibus_pkg.sv | 23 ++
 rtl/vermibus_arbiter_select.sv | 57 +++++
 rtl/vermibus_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vermibus_pkg.sv
// Shared definitions for the Vermibus arbiter.
//   - Bus widths: ADDR_W / DATA_W / STRB_W (32 / 32 / 4)
//   - MAX_CHANNELS: largest legal requester count
//   - arb_state_e: arbiter FSM state encoding
//   - idx_width(): width of a channel index (at least one bit)
package vermibus_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STRB_W       = 4;
    localparam int unsigned MAX_CHANNELS = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // A single channel still needs a one-bit index register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vermibus_arbiter_select.sv
// Combinational winner selection for the Vermibus arbiter.
// Configuration macro: VERMIBUS_ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin, search starts at ptr_i + 1 and wraps
//   undefined -> fixed priority, lowest valid index wins; ptr_i ignored
// Ports:
//   valid_i     : per-channel request valid
//   ptr_i       : last granted channel
//   idx_o       : selected channel (0 when nothing is valid)
//   any_valid_o : at least one channel is requesting
module vermibus_arbiter_select
    import vermibus_pkg::*;
#(
    parameter int unsigned N_CHANNELS = 2,
    parameter int unsigned IDX_W      = idx_width(N_CHANNELS)
) (
    input  logic [N_CHANNELS-1:0] valid_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  any_valid_o
);

    assign any_valid_o = |valid_i;

`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
    logic found;

    // Walk offsets 1..N from the pointer; the first valid channel on that
    // circular walk wins. The pointer itself is visited last.
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        for (int off = 1; off <= int'(N_CHANNELS); off++) begin
            for (int c = 0; c < int'(N_CHANNELS); c++) begin
                if (!found && valid_i[c] &&
                    (c == ((int'(ptr_i) + off) % int'(N_CHANNELS)))) begin
                    found = 1'b1;
                    idx_o = IDX_W'(c);
                end
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Scan downward so the lowest valid index is the last assignment.
    always_comb begin
        idx_o = '0;
        for (int c = int'(N_CHANNELS) - 1; c >= 0; c--) begin
            if (valid_i[c]) begin
                idx_o = IDX_W'(c);
            end
        end
    end
`endif

endmodule

// File: rtl/vermibus_arbiter.sv
// Vermibus N-to-1 arbiter.
// Configuration macro: VERMIBUS_ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration with a last-grant pointer
//   undefined -> fixed priority (lowest index wins), no pointer register
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   req_valid/req_ready : per-channel request / transfer-complete strobe
//   req_address/wstrobe/wdata/lookahead : per-channel request payload
//   req_rdata           : read data, broadcast to every channel
//   mem_*               : the single downstream Vermibus
// One IDLE cycle separates transfers: a grant is registered in IDLE and the
// owner is forwarded combinationally to mem_* while BUSY.
// N_CHANNELS legal range is 1..MAX_CHANNELS.
module vermibus_arbiter
    import vermibus_pkg::*;
#(
    parameter int unsigned N_CHANNELS = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_CHANNELS-1:0]               req_valid,
    output logic [N_CHANNELS-1:0]               req_ready,
    input  logic [N_CHANNELS-1:0][ADDR_W-1:0]   req_address,
    input  logic [N_CHANNELS-1:0][STRB_W-1:0]   req_wstrobe,
    input  logic [N_CHANNELS-1:0][DATA_W-1:0]   req_wdata,
    output logic [N_CHANNELS-1:0][DATA_W-1:0]   req_rdata,
    input  logic [N_CHANNELS-1:0]               req_lookahead,
    output logic                                mem_valid,
    input  logic                                mem_ready,
    output logic [ADDR_W-1:0]                   mem_address,
    output logic [STRB_W-1:0]                   mem_wstrobe,
    output logic [DATA_W-1:0]                   mem_wdata,
    input  logic [DATA_W-1:0]                   mem_rdata,
    output logic                                mem_lookahead
);

    localparam int unsigned IDX_W = idx_width(N_CHANNELS);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] grant_ptr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;

    // Owner's request, selected by comparison rather than indexing so that
    // non-power-of-two channel counts never read out of range.
    logic              own_valid;
    logic [ADDR_W-1:0] own_address;
    logic [STRB_W-1:0] own_wstrobe;
    logic [DATA_W-1:0] own_wdata;
    logic              own_lookahead;

`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q, last_d;
    assign grant_ptr = last_q;
`else
    assign grant_ptr = '0;
`endif

    vermibus_arbiter_select #(
        .N_CHANNELS (N_CHANNELS),
        .IDX_W      (IDX_W)
    ) u_select (
        .valid_i     (req_valid),
        .ptr_i       (grant_ptr),
        .idx_o       (sel_idx),
        .any_valid_o (sel_any)
    );

    // Next-state logic. The owner is held for the whole transfer; only
    // mem_ready (or reset) ends BUSY, even if the owner drops req_valid.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    state_d = ST_BUSY;
                    owner_d = sel_idx;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
                    last_d  = owner_q;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
            // Pointing at the top channel makes the first grant search from 0.
            last_q  <= IDX_W'(N_CHANNELS - 1);
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        own_valid     = 1'b0;
        own_address   = '0;
        own_wstrobe   = '0;
        own_wdata     = '0;
        own_lookahead = 1'b0;
        for (int i = 0; i < int'(N_CHANNELS); i++) begin
            if (int'(owner_q) == i) begin
                own_valid     = req_valid[i];
                own_address   = req_address[i];
                own_wstrobe   = req_wstrobe[i];
                own_wdata     = req_wdata[i];
                own_lookahead = req_lookahead[i];
            end
        end
    end

    // Downstream bus is quiet in IDLE; BUSY forwards the owner unchanged.
    always_comb begin
        mem_valid     = 1'b0;
        mem_address   = '0;
        mem_wstrobe   = '0;
        mem_wdata     = '0;
        mem_lookahead = 1'b0;
        req_ready     = '0;
        if (state_q == ST_BUSY) begin
            mem_valid     = own_valid;
            mem_address   = own_address;
            mem_wstrobe   = own_wstrobe;
            mem_wdata     = own_wdata;
            mem_lookahead = own_lookahead;
            for (int i = 0; i < int'(N_CHANNELS); i++) begin
                req_ready[i] = mem_ready && (int'(owner_q) == i);
            end
        end
    end

    // Read data is broadcast; only the strobed channel takes it.
    always_comb begin
        for (int i = 0; i < int'(N_CHANNELS); i++) begin
            req_rdata[i] = mem_rdata;
        end
    end

endmodule
